multicycle_controlunit: RTL and testbench

Multi-cycle RV32I control unit: a Moore FSM that sequences fetch, decode, execute, memory and writeback over several clocks on a shared-memory datapath. It generalises the single-cycle add/branch decoder to R-type, I-type ALU, lw, sw, beq, bne and jal, and adds a memory-ready handshake and illegal-instruction trapping. Sits between the instruction register and the datapath muxes, ALU, register file, PC register and unified memory.

---
 rtl/cu_pkg.sv | 65 ++++++
 rtl/multicycle_controlunit_alu_decoder.sv | 34 +++
 rtl/multicycle_controlunit.sv | 157 +++++++++++++++
 tb/tb_multicycle_controlunit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit.
// States, opcodes and datapath mux selects.
package cu_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    ALUWB,
    JAL,
    BRANCH,
    TRAP
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2 = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_sel(
    input logic [6:0] op
  );
    case (op)
      OP_SW:   imm_sel = IMM_S;
      OP_BR:   imm_sel = IMM_B;
      OP_JAL:  imm_sel = IMM_J;
      default: imm_sel = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controlunit_alu_decoder.sv
// ALU control decode from ALUOp, funct3 and funct7[5].
// Flags funct3 values this core does not implement.
module alu_decoder
  import cu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       opb5,
  output logic [2:0] aluctrl,
  output logic       unsup
);

  always_comb begin
    aluctrl = ALU_ADD;
    unsup   = 1'b0;
    unique case (1'b1)
      (aluop == ALUOP_SUB): aluctrl = ALU_SUB;
      (aluop == ALUOP_FN): begin
        case (funct3)
          // sub only exists for register-register ops
          3'b000:  aluctrl = (opb5 && funct7b5)
                             ? ALU_SUB : ALU_ADD;
          3'b111:  aluctrl = ALU_AND;
          3'b110:  aluctrl = ALU_OR;
          3'b010:  aluctrl = ALU_SLT;
          default: unsup   = 1'b1;
        endcase
      end
      default: aluctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controlunit.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute,
// memory and writeback with memory handshake and trapping.
module multicycle_controlunit
  import cu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ALUCTRL_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     instr,
  input  logic                 EQ,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [ALUCTRL_W-1:0] ALUctrl,
  output logic [1:0]           ImmSrc,
  output logic                 instr_done,
  output logic                 illegal
);

  state_t     state, nxt;
  logic       ill_q;
  logic [1:0] aluop;
  logic [2:0] aluctrl;
  logic       unsup;
  logic [6:0] op;
  logic [2:0] f3;
  logic       unused;

  assign op     = instr[6:0];
  assign f3     = instr[14:12];
  assign unused = ^{instr[WIDTH-1:31],
                    instr[29:15], instr[11:7]};

  alu_decoder u_aludec (
    .aluop    (aluop),
    .funct3   (f3),
    .funct7b5 (instr[30]),
    .opb5     (op[5]),
    .aluctrl  (aluctrl),
    .unsup    (unsup)
  );

  assign ALUctrl = ALUCTRL_W'(aluctrl);
  assign ImmSrc  = imm_sel(op);
  assign illegal = ill_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
      ill_q <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt == TRAP) ill_q <= 1'b1;
    end
  end

  always_comb begin
    nxt        = state;
    aluop      = ALUOP_ADD;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    instr_done = 1'b0;
    unique case (state)
      FETCH: begin
        ALUSrcB   = SRCB_4;
        ResultSrc = RES_ALU;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) nxt = DECODE;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_R:   nxt = EXEC_R;
          OP_I:   nxt = EXEC_I;
          OP_LW,
          OP_SW:  nxt = MEMADR;
          OP_BR:  nxt = (f3[2:1] == 2'b00)
                        ? BRANCH : TRAP;
          OP_JAL: nxt = JAL;
          default: nxt = TRAP;
        endcase
      end
      EXEC_R: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        aluop   = ALUOP_FN;
        nxt     = unsup ? TRAP : ALUWB;
      end
      EXEC_I: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        aluop   = ALUOP_FN;
        nxt     = unsup ? TRAP : ALUWB;
      end
      MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        nxt     = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) nxt = MEMWB;
      end
      MEMWB: begin
        ResultSrc  = RES_MEM;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) nxt = FETCH;
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_4;
        PCWrite = 1'b1;
        nxt     = ALUWB;
      end
      BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        aluop      = ALUOP_SUB;
        // funct3[0] distinguishes bne from beq
        PCWrite    = f3[0] ? !EQ : EQ;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      TRAP:    nxt = TRAP;
      default: nxt = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controlunit.sv
// Directed bench for the multi-cycle control unit.
// Output vector compared each cycle against hand values.
module tb_multicycle_controlunit;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        EQ;
  logic        mr;
  logic        PCWrite, IRWrite, AdrSrc, MemWrite;
  logic        RegWrite, instr_done, illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUctrl;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] SUB  = 32'h402081B3;
  localparam logic [31:0] LW   = 32'h00802203;
  localparam logic [31:0] SW   = 32'h00402423;
  localparam logic [31:0] BNE  = 32'h00209463;
  localparam logic [31:0] BEQ  = 32'h00208463;
  localparam logic [31:0] JALI = 32'h008000EF;
  localparam logic [31:0] BAD  = 32'hFFFFFFFF;
  localparam logic [31:0] SLL  = 32'h00209133;

  multicycle_controlunit #(
    .WIDTH     (32),
    .ALUCTRL_W (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .EQ         (EQ),
    .mem_ready  (mr),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUctrl    (ALUctrl),
    .ImmSrc     (ImmSrc),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // vector order: pcw irw adr mw rw rs sa sb alu imm done ill
  task automatic chk(
    input string      tag,
    input logic       pcw, irw, adr, mw, rw,
    input logic [1:0] rs, sa, sb,
    input logic [2:0] alu,
    input logic [1:0] imm,
    input logic       done, ill
  );
    logic [17:0] o, e;
    o = {PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite,
         ResultSrc, ALUSrcA, ALUSrcB, ALUctrl, ImmSrc,
         instr_done, illegal};
    e = {pcw, irw, adr, mw, rw, rs, sa, sb, alu, imm,
         done, ill};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s got=%05h exp=%05h", tag, o, e);
    end
  endtask

  task automatic chk_f(input string tag, input logic [1:0] imm);
    chk(tag, 1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000,
        imm, 0, 0);
  endtask

  task automatic chk_d(input string tag, input logic [1:0] imm);
    chk(tag, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000,
        imm, 0, 0);
  endtask

  task automatic chk_wb(input string tag, input logic [1:0] imm);
    chk(tag, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000,
        imm, 1, 0);
  endtask

  initial begin
    clk   = 0;
    rst_n = 0;
    instr = ADDI;
    EQ    = 0;
    mr    = 1;
    @(negedge clk); chk_f("reset", 2'b00);
    rst_n = 1;

    // addi
    @(negedge clk); chk_d("addi_dec", 2'b00);
    @(negedge clk);
    chk("addi_ex", 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01,
        3'b000, 2'b00, 0, 0);
    @(negedge clk); chk_wb("addi_wb", 2'b00);

    // sub
    instr = SUB;
    @(negedge clk); chk_f("sub_f", 2'b00);
    @(negedge clk); chk_d("sub_dec", 2'b00);
    @(negedge clk);
    chk("sub_ex", 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00,
        3'b001, 2'b00, 0, 0);
    @(negedge clk); chk_wb("sub_wb", 2'b00);

    // lw with two wait cycles
    instr = LW;
    @(negedge clk); chk_f("lw_f", 2'b00);
    @(negedge clk); chk_d("lw_dec", 2'b00);
    @(negedge clk);
    chk("lw_adr", 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01,
        3'b000, 2'b00, 0, 0);
    mr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lw_rd", 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00,
          3'b000, 2'b00, 0, 0);
    end
    mr = 1;
    @(negedge clk);
    chk("lw_wb", 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00,
        3'b000, 2'b00, 1, 0);

    // sw with one wait cycle
    instr = SW;
    @(negedge clk); chk_f("sw_f", 2'b01);
    @(negedge clk); chk_d("sw_dec", 2'b01);
    @(negedge clk);
    chk("sw_adr", 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01,
        3'b000, 2'b01, 0, 0);
    mr = 0;
    @(negedge clk);
    chk("sw_wr1", 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00,
        3'b000, 2'b01, 0, 0);
    @(posedge clk); #1 mr = 1;
    @(negedge clk);
    chk("sw_wr2", 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00,
        3'b000, 2'b01, 1, 0);

    // bne taken / not taken, beq taken
    instr = BNE;
    @(negedge clk); chk_f("bne_f", 2'b10);
    @(negedge clk); chk_d("bne_dec", 2'b10);
    @(negedge clk);
    chk("bne_tk", 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00,
        3'b001, 2'b10, 1, 0);
    EQ = 1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("bne_nt", 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00,
        3'b001, 2'b10, 1, 0);
    instr = BEQ;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("beq_tk", 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00,
        3'b001, 2'b10, 1, 0);
    EQ = 0;

    // jal
    instr = JALI;
    @(negedge clk); chk_f("jal_f", 2'b11);
    @(negedge clk); chk_d("jal_dec", 2'b11);
    @(negedge clk);
    chk("jal_ex", 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10,
        3'b000, 2'b11, 0, 0);
    @(negedge clk); chk_wb("jal_wb", 2'b11);

    // bad opcode traps until reset
    instr = BAD;
    @(negedge clk); chk_f("bad_f", 2'b00);
    @(negedge clk); chk_d("bad_dec", 2'b00);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("trap", 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00,
          3'b000, 2'b00, 0, 1);
    end
    rst_n = 0;
    @(negedge clk); chk_f("trap_rst", 2'b00);
    rst_n = 1;

    // unsupported R funct3 traps from EXEC_R
    instr = SLL;
    @(negedge clk); @(negedge clk);
    @(negedge clk);
    chk("sll_trap", 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00,
        3'b000, 2'b00, 0, 1);
    rst_n = 0;
    @(negedge clk); chk_f("sll_rst", 2'b00);
    rst_n = 1;

    // reset in the middle of a store
    instr = SW;
    @(negedge clk); @(negedge clk);
    mr = 0;
    @(negedge clk);
    chk("swr_wr", 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00,
        3'b000, 2'b01, 0, 0);
    rst_n = 0;
    @(negedge clk);
    chk("swr_rst", 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10,
        3'b000, 2'b01, 0, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
